// File: rtl/deadlock_mon_pkg.sv
// Shared types and helpers for the AXI-Stream deadlock monitor.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_WATCH   = 2'd1,
    MON_BLOCKED = 2'd2
  } mon_st_e;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Encoded block info for channel idx in an n-bit field: every bit set
  // except the channel's own position.
  function automatic logic [31:0] info_field(input int idx, input int n);
    logic [31:0] m;
    m = ~(32'd1 << idx);
    if (n < 32) m = m & ((32'd1 << n) - 32'd1);
    return m;
  endfunction

endpackage

// File: rtl/deadlock_stall_cnt.sv
// Per-channel stall persistence counter: debounces one AXIS blocking flag
// against the programmable threshold and keeps the channel's flag.
module deadlock_stall_cnt #(
  parameter int CNT_W  = 16,
  parameter bit STICKY = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             stall_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             hit_o,
  output logic             flag_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [CNT_W:0]   cnt_inc, thr_eff;

  // Threshold compare is done one bit wider so a saturated count never wraps.
  always_comb begin
    thr_eff = (thresh_i == '0) ? (CNT_W+1)'(1) : {1'b0, thresh_i};
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    hit_o   = stall_i & (cnt_inc >= thr_eff);
  end

  // Next count (saturating, drops to zero when the stall goes away) and flag.
  always_comb begin
    cnt_d  = '0;
    flag_d = 1'b0;
    if (!clear) begin
      if (stall_i) cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
      flag_d = STICKY ? (flag_q | hit_o) : hit_o;
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/axis_deadlock_monitor.sv
// Deadlock monitor for one HLS instance: aggregates debounced AXIS stalls and
// non-idle child monitor blocks into a registered block indication, with
// first-blocking channel and saturating block duration.
module axis_deadlock_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS = 2,
  parameter int N_SUB  = 1,
  parameter int CNT_W  = 16,
  parameter bit STICKY = 1'b0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_AXIS-1:0]                  axis_block_sigs,
  input  logic [N_SUB-1:0]                   inst_idle_sigs,
  input  logic [N_SUB-1:0]                   sub_block_sigs,
  input  logic [CNT_W-1:0]                   thresh,
  input  logic                               clear,
  output logic [N_AXIS*N_AXIS-1:0]           axis_block_info,
  output logic                               block,
  output logic [clog2_min1(N_AXIS)-1:0]      first_ch,
  output logic [CNT_W-1:0]                   block_cycles
);

  localparam int FCH_W = clog2_min1(N_AXIS);

  logic [N_AXIS-1:0] hit, flag;
  logic              sub_hit, block_q, block_d, entering;
  mon_st_e           st_q, st_d;
  logic [FCH_W-1:0]  first_q, first_d, low_idx;
  logic [CNT_W-1:0]  bc_q, bc_d;

  for (genvar g = 0; g < N_AXIS; g++) begin : g_ch
    localparam logic [31:0] FIELD = info_field(g, N_AXIS);

    deadlock_stall_cnt #(.CNT_W(CNT_W), .STICKY(STICKY)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .stall_i  (axis_block_sigs[g]),
      .thresh_i (thresh),
      .hit_o    (hit[g]),
      .flag_o   (flag[g])
    );

    // Gated by block so the info bus is quiet whenever nothing is reported.
    assign axis_block_info[g*N_AXIS +: N_AXIS] =
      (flag[g] & block_q) ? FIELD[N_AXIS-1:0] : '0;
  end

  // Aggregate block and lowest-index hit channel.
  always_comb begin
    sub_hit  = |(sub_block_sigs & ~inst_idle_sigs);
    block_d  = ~clear & ((|hit) | sub_hit | (STICKY & (|flag)));
    entering = block_d & (st_q != MON_BLOCKED);
    low_idx  = '0;
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (hit[i]) low_idx = FCH_W'(i);
    end
  end

  // FSM next state plus first-channel latch and duration counter.
  always_comb begin
    st_d    = MON_IDLE;
    first_d = first_q;
    bc_d    = bc_q;
    if (clear) begin
      first_d = '0;
      bc_d    = '0;
    end else begin
      if (block_d)               st_d = MON_BLOCKED;
      else if (|axis_block_sigs) st_d = MON_WATCH;
      if (entering) begin
        first_d = low_idx;
        bc_d    = CNT_W'(1);
      end else if (st_q == MON_BLOCKED && block_d && !(&bc_q)) begin
        bc_d = bc_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q    <= MON_IDLE;
      block_q <= 1'b0;
      first_q <= '0;
      bc_q    <= '0;
    end else begin
      st_q    <= st_d;
      block_q <= block_d;
      first_q <= first_d;
      bc_q    <= bc_d;
    end
  end

  assign block        = block_q;
  assign first_ch     = first_q;
  assign block_cycles = bc_q;

endmodule
